// File: rtl/flash_arb_pkg.sv
// Shared definitions for the SPI flash arbiter.
// Contents: FSM state encoding, well-known requester indices, and a
// constant-evaluable ceiling-log2 helper for sizing index/counter fields.
package flash_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OWNED = 2'b01,
    ST_GAP   = 2'b10
  } arb_state_t;

  localparam int REQ_CHAN  = 0;
  localparam int REQ_IPBUS = 1;

  // Ceiling log2 with a floor of 1 so a field is never zero bits wide.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((64'(1) << r) < 64'(value)) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_flash_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
// Ports:
//   eligible   in  NREQ  requesters allowed to win this cycle
//   last_owner in  OW    previous owner; the search starts one above it
//   winner     out OW    first eligible index in search order
//   valid      out 1     at least one requester is eligible
module rr_picker
  import flash_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int OW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [OW-1:0]   last_owner,
  output logic [OW-1:0]   winner,
  output logic            valid
);

  // Walk the search order backwards so the last hit written is the first
  // index after last_owner (modulo NREQ), i.e. the round-robin winner.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      int idx;
      idx = (int'(last_owner) + k) % NREQ;
      if (eligible[idx]) begin
        winner = OW'(idx);
        valid  = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter: shares one SPI flash interface between NREQ requesters.
// One owner at a time, round-robin fairness, a fixed idle gap between
// owners and a watchdog that force-releases an owner holding too long.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   req               level request per requester
//   cmd_valid         one-cycle command strobe per requester
//   cmd_data          packed payloads, requester i at [i*CMD_W +: CMD_W]
//   flash_busy        flash interface is executing a command
//   grant             one-hot registered grant
//   owner             index of the current or last owner
//   flash_cmd_valid   owner's strobe, registered
//   flash_cmd_data    owner's payload, registered, held between strobes
//   timeout_flags     sticky per-requester force-release flags
//   clear_flags       pulse to clear timeout_flags
//   arb_busy          high in every state except IDLE
module spi_flash_arbiter
  import flash_arb_pkg::*;
#(
  parameter int NREQ           = 3,
  parameter int CMD_W          = 32,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 16777216,
  localparam int OW            = clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       cmd_valid,
  input  logic [NREQ*CMD_W-1:0] cmd_data,
  input  logic                  flash_busy,
  output logic [NREQ-1:0]       grant,
  output logic [OW-1:0]         owner,
  output logic                  flash_cmd_valid,
  output logic [CMD_W-1:0]      flash_cmd_data,
  output logic [NREQ-1:0]       timeout_flags,
  input  logic                  clear_flags,
  output logic                  arb_busy
);

  localparam int WD_W  = clog2(TIMEOUT_CYCLES) + 1;
  localparam int GAP_W = 4;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [NREQ-1:0]  ONE_HOT0 = NREQ'(1'b1);

  arb_state_t        state_r, state_s;
  logic [NREQ-1:0]   grant_s;
  logic [OW-1:0]     owner_s;
  logic [WD_W-1:0]   wd_r, wd_s;
  logic [GAP_W-1:0]  gap_r, gap_s;
  logic              timeout_s;
  logic [NREQ-1:0]   mask_r, mask_s;
  logic [NREQ-1:0]   flags_s;
  logic [NREQ-1:0]   eligible_s;
  logic [OW-1:0]     pick_owner_s;
  logic              pick_valid_s;
  logic              fwd_valid_s;
  logic [CMD_W-1:0]  owner_payload_s;

  assign eligible_s      = req & ~mask_r;
  assign fwd_valid_s     = (state_r == ST_OWNED) && cmd_valid[owner];
  assign owner_payload_s = cmd_data[int'(owner) * CMD_W +: CMD_W];

  rr_picker #(
    .NREQ (NREQ),
    .OW   (OW)
  ) u_picker (
    .eligible   (eligible_s),
    .last_owner (owner),
    .winner     (pick_owner_s),
    .valid      (pick_valid_s)
  );

  // Next-state logic for the grant FSM, watchdog and gap counter.
  // The final gap cycle also arbitrates, so the bus sees exactly
  // GAP_CYCLES grant-free cycles between consecutive owners.
  always_comb begin
    state_s   = state_r;
    grant_s   = grant;
    owner_s   = owner;
    wd_s      = wd_r;
    gap_s     = gap_r;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_s = ST_OWNED;
          grant_s = ONE_HOT0 << pick_owner_s;
          owner_s = pick_owner_s;
          wd_s    = '0;
        end else begin
          grant_s = '0;
        end
      end
      ST_OWNED: begin
        if (!req[owner] && !flash_busy) begin
          state_s = ST_GAP;
          grant_s = '0;
          gap_s   = '0;
        end else if (wd_r == WD_LAST) begin
          timeout_s = 1'b1;
          state_s   = ST_GAP;
          grant_s   = '0;
          gap_s     = '0;
        end else begin
          wd_s = wd_r + 1'b1;
        end
      end
      ST_GAP: begin
        grant_s = '0;
        if (gap_r == GAP_LAST) begin
          if (pick_valid_s) begin
            state_s = ST_OWNED;
            grant_s = ONE_HOT0 << pick_owner_s;
            owner_s = pick_owner_s;
            wd_s    = '0;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          gap_s = gap_r + 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = '0;
      end
    endcase
  end

  // Sticky flags and drop mask. A timeout's own bit survives a
  // simultaneous clear; a mask bit clears once its request is seen low.
  always_comb begin
    if (clear_flags) begin
      flags_s = '0;
    end else begin
      flags_s = timeout_flags;
    end
    mask_s = mask_r & req;
    if (timeout_s) begin
      flags_s[owner] = 1'b1;
      mask_s[owner]  = 1'b1;
    end else begin
      mask_s = mask_s;
    end
  end

  // FSM state, grant, owner and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      grant    <= '0;
      owner    <= OW'(NREQ - 1);
      wd_r     <= '0;
      gap_r    <= '0;
      arb_busy <= 1'b0;
    end else begin
      state_r  <= state_s;
      grant    <= grant_s;
      owner    <= owner_s;
      wd_r     <= wd_s;
      gap_r    <= gap_s;
      arb_busy <= (state_s != ST_IDLE);
    end
  end

  // Command forwarding, flags and drop mask registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      flash_cmd_valid <= 1'b0;
      flash_cmd_data  <= '0;
      timeout_flags   <= '0;
      mask_r          <= '0;
    end else begin
      flash_cmd_valid <= fwd_valid_s;
      if (fwd_valid_s) begin
        flash_cmd_data <= owner_payload_s;
      end else begin
        flash_cmd_data <= flash_cmd_data;
      end
      timeout_flags <= flags_s;
      mask_r        <= mask_s;
    end
  end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed testbench for spi_flash_arbiter (NREQ=3, GAP=4, TIMEOUT=100).
module tb_spi_flash_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req;
  logic [2:0]  cmd_valid;
  logic [95:0] cmd_data;
  logic        flash_busy;
  logic [2:0]  grant;
  logic [1:0]  owner;
  logic        flash_cmd_valid;
  logic [31:0] flash_cmd_data;
  logic [2:0]  timeout_flags;
  logic        clear_flags;
  logic        arb_busy;

  int n_cmp = 0;
  int n_mis = 0;

  spi_flash_arbiter #(
    .NREQ           (3),
    .CMD_W          (32),
    .GAP_CYCLES     (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .cmd_valid       (cmd_valid),
    .cmd_data        (cmd_data),
    .flash_busy      (flash_busy),
    .grant           (grant),
    .owner           (owner),
    .flash_cmd_valid (flash_cmd_valid),
    .flash_cmd_data  (flash_cmd_data),
    .timeout_flags   (timeout_flags),
    .clear_flags     (clear_flags),
    .arb_busy        (arb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: outputs are stable and inputs may change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req         = 3'b000;
    cmd_valid   = 3'b000;
    cmd_data    = 96'h0;
    flash_busy  = 1'b0;
    clear_flags = 1'b0;
    reset       = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int held;
  int zeros;
  int bad;
  logic [2:0] exp_order [4];

  initial begin
    exp_order[0] = 3'b001;
    exp_order[1] = 3'b010;
    exp_order[2] = 3'b100;
    exp_order[3] = 3'b001;

    // Reset state
    do_reset();
    check_val("rst_grant", 64'(grant), 64'h0);
    check_val("rst_owner", 64'(owner), 64'h2);
    check_val("rst_busy", 64'(arb_busy), 64'h0);
    check_val("rst_fcv", 64'(flash_cmd_valid), 64'h0);
    check_val("rst_fcd", 64'(flash_cmd_data), 64'h0);
    check_val("rst_flags", 64'(timeout_flags), 64'h0);

    // Single request from reset
    req = 3'b010;
    tick();
    check_val("single_grant", 64'(grant), 64'h2);
    check_val("single_owner", 64'(owner), 64'h1);
    check_val("single_busy", 64'(arb_busy), 64'h1);
    req = 3'b000;
    tick();
    check_val("single_release", 64'(grant), 64'h0);
    check_val("single_gap_busy", 64'(arb_busy), 64'h1);
    tick(); tick(); tick();
    check_val("single_busy_3", 64'(arb_busy), 64'h1);
    tick();
    check_val("single_busy_4", 64'(arb_busy), 64'h0);

    // Three-way tie, each owner holding 10 cycles then pulsing req low
    do_reset();
    req = 3'b111;
    tick();
    for (int r = 0; r < 4; r++) begin
      check_val($sformatf("rr_grant%0d", r), 64'(grant), 64'(exp_order[r]));
      for (int c = 0; c < 9; c++) tick();
      check_val($sformatf("rr_hold%0d", r), 64'(grant), 64'(exp_order[r]));
      if (r < 3) begin
        req = req & ~grant;
        tick();
        req = 3'b111;
        zeros = 0;
        while (grant == 3'b000 && zeros < 50) begin
          zeros++;
          tick();
        end
        check_val($sformatf("rr_gap%0d", r), 64'(zeros), 64'd4);
      end
    end
    req = 3'b000;

    // Release while flash busy
    do_reset();
    req = 3'b001;
    tick();
    check_val("busy_grant", 64'(grant), 64'h1);
    req = 3'b000;
    flash_busy = 1'b1;
    held = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (grant == 3'b001) held++;
    end
    check_val("busy_held", 64'(held), 64'd20);
    flash_busy = 1'b0;
    tick();
    check_val("busy_release", 64'(grant), 64'h0);

    // Command isolation: owner 1 while requester 0 strobes
    do_reset();
    req = 3'b010;
    tick();
    check_val("iso_grant", 64'(grant), 64'h2);
    cmd_data[31:0] = 32'h1111_1111;
    cmd_valid = 3'b001;
    tick();
    check_val("iso_drop0", 64'(flash_cmd_valid), 64'h0);
    cmd_data[63:32] = 32'hDEAD_BEEF;
    cmd_valid = 3'b010;
    tick();
    check_val("iso_fcv", 64'(flash_cmd_valid), 64'h1);
    check_val("iso_fcd", 64'(flash_cmd_data), 64'hDEAD_BEEF);
    cmd_valid = 3'b001;
    tick();
    check_val("iso_width", 64'(flash_cmd_valid), 64'h0);
    cmd_valid = 3'b000;
    tick();
    check_val("iso_idle", 64'(flash_cmd_valid), 64'h0);
    check_val("iso_hold", 64'(flash_cmd_data), 64'hDEAD_BEEF);
    cmd_data[63:32] = 32'hCAFE_F00D;
    cmd_valid = 3'b011;
    tick();
    cmd_valid = 3'b000;
    check_val("iso_both_fcv", 64'(flash_cmd_valid), 64'h1);
    check_val("iso_both_fcd", 64'(flash_cmd_data), 64'hCAFE_F00D);

    // Watchdog force release
    do_reset();
    req = 3'b001;
    tick();
    held = 0;
    while (grant == 3'b001 && held < 200) begin
      held++;
      tick();
    end
    check_val("wd_held", 64'(held), 64'd100);
    check_val("wd_release", 64'(grant), 64'h0);
    check_val("wd_flags", 64'(timeout_flags), 64'h1);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (grant != 3'b000) bad++;
    end
    check_val("wd_no_regrant", 64'(bad), 64'd0);
    check_val("wd_idle", 64'(arb_busy), 64'h0);
    req = 3'b000;
    tick();
    req = 3'b001;
    tick();
    check_val("wd_regrant", 64'(grant), 64'h1);
    check_val("wd_sticky", 64'(timeout_flags), 64'h1);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check_val("wd_clear", 64'(timeout_flags), 64'h0);

    // Reset mid-grant
    do_reset();
    req = 3'b100;
    tick();
    check_val("mid_grant", 64'(grant), 64'h4);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("mid_drop", 64'(grant), 64'h0);
    check_val("mid_busy", 64'(arb_busy), 64'h0);
    check_val("mid_owner", 64'(owner), 64'h2);
    req = 3'b101;
    tick();
    check_val("mid_fresh", 64'(grant), 64'h1);
    req = 3'b000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
